fp_norm_seq: RTL
================

// Module: fp_norm_seq
// PURPOSE
//   Multi-cycle normalisation sequencer for the floating-point adder datapath.
//   - Takes the raw post-add sum: sign, exponent, and mantissa with carry-out bit.
//   - Locates the leading one with a one-hot detect followed by an encode.
//   - Drives a bounded-width left shifter over several cycles, adjusting the exponent each step.
//   - Returns a normalised result with overflow/underflow flags via valid/ready.
// PARAMETERS
//   MANT_W   24  mantissa width incl. hidden bit; input carries MANT_W+1 bits
//   EXP_W    8   biased exponent width; all-ones = overflow/infinity code
//   STEP     4   max left-shift positions per SHIFT cycle, legal range 1..MANT_W
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          input operand valid
//   in_ready   out  1          block can accept; high only in IDLE
//   in_sign    in   1          sum sign
//   in_exp     in   EXP_W      sum exponent (biased)
//   in_mant    in   MANT_W+1   sum mantissa; bit MANT_W = adder carry-out
//   out_valid  out  1          result valid; held until out_ready
//   out_ready  in   1          consumer accepts result
//   out_sign   out  1          result sign (passed through)
//   out_exp    out  EXP_W      normalised exponent
//   out_mant   out  MANT_W     normalised mantissa, hidden bit at MANT_W-1
//   out_ovf    out  1          exponent overflow; result forced to infinity
//   out_unf    out  1          exponent underflow; result flushed to zero
//   busy       out  1          state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; out_valid, out_sign, out_exp, out_mant, out_ovf, out_unf, busy = 0; in_ready=1.
//   Internal registers reset to 0; a reset in any state aborts the operation, no output produced.
//   States: IDLE -> EVAL -> (SHIFT)* -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, latch sign/exp/mant and go to EVAL.
//   EVAL (one cycle), first matching rule wins:
//     - mant==0: exp=0, mant=0, flags 0 -> DONE.
//     - mant[MANT_W]=1: mant>>=1 and exp+=1.
//       - If new exp==all-ones: out_ovf=1, mant=0 -> DONE.
//       - Else -> DONE.
//     - Otherwise lz = leading zeros of mant[MANT_W-1:0], from one-hot leading-one detect + binary encode.
//       - lz==0 -> DONE.
//       - lz >= exp (incl. exp==0): out_unf=1, exp=0, mant=0 -> DONE.
//       - Else rem=lz -> SHIFT.
//   SHIFT, per cycle: k=min(rem,STEP); mant<<=k; exp-=k; rem-=k. Go to DONE in the same cycle rem reaches 0.
//   DONE: out_valid=1 and all out_* registered and stable. On out_ready go to IDLE.
//     out_valid drops next cycle.
//   Latency: accept edge T, EVAL result at T+1, out_valid high from T+2+ceil(lz/STEP).
//     No-shift cases: out_valid high from T+2.
//   No overlap: a new input is accepted only from IDLE, the cycle after the DONE handshake.
//   in_valid during busy is ignored; in_* is don't-care outside IDLE.
//   Flags out_ovf/out_unf are valid only with out_valid; cleared on entry to EVAL.
//   Exponent arithmetic is EXP_W+1 bits internally. No wrap is possible, since the underflow check precedes SHIFT.
// TESTING
//   1 mant=0x0800000, exp=127, STEP=4 -> out_mant=0x800000, exp=127, flags 0.
//     out_valid at accept+2.
//   2 mant=0x1000000, exp=127 -> mant=0x800000, exp=128.
//     Same mant with exp=254 -> out_ovf=1, exp=255, mant=0.
//   3 mant=0x0000001, exp=100, STEP=4 -> lz=23, 6 SHIFT cycles.
//     Expect exp=77, mant=0x800000, out_valid at accept+8.
//     Repeat with STEP=1: out_valid at accept+25.
//   4 mant=0x0000100, exp=10 (lz=15>=10) -> out_unf=1, exp=0, mant=0.
//     mant=0 -> zero result, flags 0.
//   5 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored.
//     Then out_ready=1 -> IDLE, next operand accepted one cycle later.
//   6 Assert rst_n=0 mid-SHIFT -> all outputs at reset values immediately.
//     After release, in_ready=1 and a fresh operand completes correctly.

Source files
------------

// File: rtl/fp_norm_seq.sv
// Multi-cycle normalisation sequencer for the FP adder: resolves carry-out or
// leading zeros of the raw sum, shifting at most STEP positions per cycle.
module fp_norm_seq #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              busy
);

    localparam int LZ_W = $clog2(MANT_W + 1);
    localparam int EW1  = EXP_W + 1;
    localparam logic [LZ_W-1:0] STEP_L  = LZ_W'(STEP);
    localparam logic [EXP_W:0]  EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_SHIFT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [MANT_W:0]   mant_q, mant_d;
    logic [LZ_W-1:0]   rem_q, rem_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [MANT_W-1:0] smear, onehot;
    logic [LZ_W-1:0]   lead_idx, lz, k;

    // Leading-one detect: smear ones downward, keep only the top one, then encode.
    always_comb begin
        smear = mant_q[MANT_W-1:0];
        for (int unsigned i = 1; i < MANT_W; i = i * 2)
            smear = smear | (smear >> i);
        onehot   = smear & ~(smear >> 1);
        lead_idx = '0;
        for (int unsigned i = 0; i < MANT_W; i++)
            if (onehot[i]) lead_idx = lead_idx | LZ_W'(i);
        lz = LZ_W'(MANT_W - 1) - lead_idx;
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        k       = (rem_q < STEP_L) ? rem_q : STEP_L;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {1'b0, in_exp};
                    mant_d  = in_mant;
                    rem_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = S_DONE;
                if (mant_q == '0) begin
                    exp_d = '0;
                end else if (mant_q[MANT_W]) begin
                    exp_d = exp_q + 1'b1;
                    if (exp_d >= EXP_MAX) begin
                        ovf_d  = 1'b1;
                        exp_d  = EXP_MAX;
                        mant_d = '0;
                    end else begin
                        mant_d = mant_q >> 1;
                    end
                end else if (lz == '0) begin
                    state_d = S_DONE;
                end else if (int'(lz) >= int'(exp_q)) begin
                    unf_d  = 1'b1;
                    exp_d  = '0;
                    mant_d = '0;
                end else begin
                    rem_d   = lz;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                mant_d = mant_q << k;
                exp_d  = exp_q - EW1'(k);
                rem_d  = rem_q - k;
                if (rem_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sign  = sign_q;
    assign out_exp   = exp_q[EXP_W-1:0];
    assign out_mant  = mant_q[MANT_W-1:0];
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

endmodule
